// File: rtl/axis_spi_master_pkg.sv
// Shared SPI master definitions: default widths and the shift-engine FSM states.
package axis_spi_master_pkg;

    localparam int unsigned DATA_WIDTH    = 8;
    localparam int unsigned DIVIDER_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL
    } spi_master_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period down-counter: emits a one-cycle tick every div_i cycles, restarted by load_i.
module spi_sclk_gen #(
    parameter int unsigned WIDTH = axis_spi_master_pkg::DIVIDER_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] div_i,
    output logic             tick_c
);

    logic [WIDTH-1:0] cnt_q;

    // Counts div_i-1 down to 0; div_i is never 0, so no wrap inside a half-period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i || tick_c) begin
            cnt_q <= div_i - WIDTH'(1);
        end else begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign tick_c = (cnt_q == '0);

endmodule

// File: rtl/axis_spi_master.sv
// SPI master shift engine: one MSB-first word per CS frame between AXI-Stream and the SPI pins.
module axis_spi_master #(
    parameter int unsigned DATA_WIDTH    = axis_spi_master_pkg::DATA_WIDTH,
    parameter int unsigned DIVIDER_WIDTH = axis_spi_master_pkg::DIVIDER_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
    input  logic                     cpol_i,
    input  logic                     cpha_i,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     spi_sclk_o,
    output logic                     spi_cs_n_o,
    output logic                     spi_mosi_o,
    input  logic                     spi_miso_i,
    output logic                     busy_o
);

    import axis_spi_master_pkg::*;

    localparam int unsigned EDGE_W = $clog2(2 * DATA_WIDTH);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);

    spi_master_state_e        state_q, state_next_c;
    logic [DIVIDER_WIDTH-1:0] div_q, div_eff_c, div_sel_c;
    logic                     cpol_q, cpha_q, done_q;
    logic [EDGE_W-1:0]        edge_q;
    logic [DATA_WIDTH-2:0]    tx_q;
    logic [DATA_WIDTH-1:0]    rx_q;
    logic                     accept_c, load_c, tick_c;
    logic                     edge_c, sample_c, shift_c, trail_end_c;

    assign s_axis_tready = (state_q == IDLE) & ~m_axis_tvalid & ~rst_i;
    assign accept_c      = s_axis_tvalid & s_axis_tready;
    assign div_eff_c     = (clk_divider_i == '0) ? DIVIDER_WIDTH'(1) : clk_divider_i;
    assign div_sel_c     = (state_q == IDLE) ? div_eff_c : div_q;
    assign load_c        = (state_q == IDLE) | (state_next_c != state_q);

    spi_sclk_gen #(
        .WIDTH (DIVIDER_WIDTH)
    ) u_sclk_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (load_c),
        .div_i  (div_sel_c),
        .tick_c (tick_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_next_c;
    end

    always_comb begin
        state_next_c = state_q;
        unique case (state_q)
            IDLE:    if (accept_c) state_next_c = LEAD;
            LEAD:    if (tick_c) state_next_c = SHIFT;
            SHIFT:   if (tick_c && (edge_q == LAST_EDGE)) state_next_c = TRAIL;
            TRAIL:   if (done_q) state_next_c = IDLE;
            default: state_next_c = IDLE;
        endcase
    end

    // Even edge count is the leading SCLK edge; CPHA picks which edge samples and which shifts.
    always_comb begin
        edge_c      = 1'b0;
        sample_c    = 1'b0;
        shift_c     = 1'b0;
        trail_end_c = (state_q == TRAIL) && tick_c && !done_q;
        if ((state_q == SHIFT) && tick_c) begin
            edge_c = 1'b1;
            if (cpha_q) begin
                sample_c = edge_q[0];
                shift_c  = !edge_q[0] && (edge_q != '0);
            end else begin
                sample_c = !edge_q[0];
                shift_c  = edge_q[0] && (edge_q != LAST_EDGE);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q         <= '0;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            done_q        <= 1'b0;
            edge_q        <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            spi_sclk_o    <= 1'b0;
            spi_cs_n_o    <= 1'b1;
            spi_mosi_o    <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            if (state_q == IDLE) spi_sclk_o <= cpol_i;
            if (accept_c) begin
                tx_q       <= s_axis_tdata[DATA_WIDTH-2:0];
                spi_mosi_o <= s_axis_tdata[DATA_WIDTH-1];
                rx_q       <= '0;
                div_q      <= div_eff_c;
                cpol_q     <= cpol_i;
                cpha_q     <= cpha_i;
                edge_q     <= '0;
                spi_cs_n_o <= 1'b0;
                busy_o     <= 1'b1;
            end
            if (edge_c) begin
                spi_sclk_o <= edge_q[0] ? cpol_q : ~cpol_q;
                edge_q     <= edge_q + EDGE_W'(1);
            end
            if (sample_c) rx_q <= {rx_q[DATA_WIDTH-2:0], spi_miso_i};
            if (shift_c) begin
                spi_mosi_o <= tx_q[DATA_WIDTH-2];
                tx_q       <= {tx_q[DATA_WIDTH-3:0], 1'b0};
            end
            if (trail_end_c) begin
                m_axis_tdata <= rx_q;
                done_q       <= 1'b1;
                busy_o       <= 1'b0;
            end
            // The RX slot is always empty when a frame completes, so these never collide.
            if (done_q) begin
                done_q        <= 1'b0;
                m_axis_tvalid <= 1'b1;
                spi_cs_n_o    <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_spi_master.sv
// Directed bench for axis_spi_master with a behavioural SPI slave and hand-computed expectations.
module tb_axis_spi_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] clk_divider_i;
    logic        cpol_i, cpha_i;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready;
    logic        spi_sclk_o, spi_cs_n_o, spi_mosi_o, spi_miso_i, busy_o;

    axis_spi_master dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clk_divider_i (clk_divider_i),
        .cpol_i        (cpol_i),
        .cpha_i        (cpha_i),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .spi_sclk_o    (spi_sclk_o),
        .spi_cs_n_o    (spi_cs_n_o),
        .spi_mosi_o    (spi_mosi_o),
        .spi_miso_i    (spi_miso_i),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Slave configuration (written by the stimulus only)
    logic [7:0] sl_word;
    logic       loopback;
    int         exp_gap;

    // Slave state (written by the slave process only)
    logic       prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
    logic       miso_r = 1'b0, sl_lead;
    logic [7:0] sl_sh = '0, sl_rx = '0;
    int         sl_edges = 0, sl_rises = 0, last_rise = 0, gap_bad = 0, mosi_bad = 0;

    assign spi_miso_i = loopback ? spi_mosi_o : miso_r;

    // Reference SPI slave, evaluated on the falling clk edge away from DUT updates
    always @(negedge clk_i) begin
        if (!spi_cs_n_o && prev_cs) begin
            sl_edges = 0;
            sl_rises = 0;
            sl_rx    = '0;
            sl_sh    = sl_word;
            if (!cpha_i) begin
                miso_r = sl_sh[7];
                sl_sh  = sl_sh << 1;
            end
        end else if (!spi_cs_n_o) begin
            sl_lead = (spi_sclk_o != cpol_i);
            if (spi_sclk_o != prev_sclk) begin
                sl_edges++;
                if (spi_sclk_o) begin
                    if (sl_rises > 0 && (cyc - last_rise) != exp_gap) gap_bad++;
                    sl_rises++;
                    last_rise = cyc;
                end
                if (sl_lead ^ cpha_i) begin
                    sl_rx = {sl_rx[6:0], spi_mosi_o};
                end else begin
                    miso_r = sl_sh[7];
                    sl_sh  = sl_sh << 1;
                end
            end
            if (spi_mosi_o != prev_mosi &&
                !((spi_sclk_o != prev_sclk) && !(sl_lead ^ cpha_i))) mosi_bad++;
        end
        prev_cs   = spi_cs_n_o;
        prev_sclk = spi_sclk_o;
        prev_mosi = spi_mosi_o;
    end

    int n_vec = 0, n_bad = 0;
    int hs_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 2000) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n >= 2000) chk("hs_timeout", 32'd1, 32'd0);
        @(posedge clk_i); #1;
        hs_cyc        = cyc;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic pull(output logic [7:0] d, output int lat);
        int n = 0;
        while (!m_axis_tvalid && n < 5000) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n >= 5000) chk("rx_timeout", 32'd1, 32'd0);
        lat           = cyc - hs_cyc;
        d             = m_axis_tdata;
        m_axis_tready = 1'b1;
        @(posedge clk_i); #1;
        m_axis_tready = 1'b0;
        chk("rx_clear", 32'(m_axis_tvalid), 32'd0);
    endtask

    task automatic frame(input logic [7:0] tx, input logic [7:0] sw,
                         output logic [7:0] rx, output int lat);
        sl_word = sw;
        push(tx);
        pull(rx, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rx, tx, sw;
        logic [1:0] md;
        int lat, g0, m0, n, seen;

        rst_i = 1'b1; clk_divider_i = 32'd2; cpol_i = 1'b0; cpha_i = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        loopback = 1'b0; sl_word = '0; exp_gap = 4;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_cs_n",   32'(spi_cs_n_o),    32'd1);
        chk("rst_sclk",   32'(spi_sclk_o),    32'd0);
        chk("rst_mosi",   32'(spi_mosi_o),    32'd0);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata",  32'(m_axis_tdata),  32'd0);
        chk("rst_busy",   32'(busy_o),        32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("idle_tready", 32'(s_axis_tready), 32'd1);

        // Mode 0, D=2, loopback: (2*8+2)*2+1 = 37 cycles to tvalid
        loopback = 1'b1; g0 = gap_bad; m0 = mosi_bad;
        frame(8'hA5, 8'h00, rx, lat);
        chk("t1_rx",     32'(rx), 32'hA5);
        chk("t1_lat",    32'(lat), 32'd37);
        chk("t1_pulses", 32'(sl_rises), 32'd8);
        chk("t1_period", 32'(gap_bad - g0), 32'd0);
        chk("t1_mosi",   32'(mosi_bad - m0), 32'd0);
        loopback = 1'b0;

        // Mode 3, D=3: 18*3+1 = 55 cycles
        cpol_i = 1'b1; cpha_i = 1'b1; clk_divider_i = 32'd3; exp_gap = 6;
        repeat (2) @(posedge clk_i);
        #1;
        chk("t2_idle_sclk", 32'(spi_sclk_o), 32'd1);
        m0 = mosi_bad;
        frame(8'hC3, 8'h3C, rx, lat);
        chk("t2_rx",       32'(rx), 32'h3C);
        chk("t2_slave_rx", 32'(sl_rx), 32'hC3);
        chk("t2_lat",      32'(lat), 32'd55);
        chk("t2_mosi",     32'(mosi_bad - m0), 32'd0);

        // Backpressure: second word held off until the first RX beat is taken
        cpol_i = 1'b0; cpha_i = 1'b0; clk_divider_i = 32'd1; exp_gap = 2;
        repeat (2) @(posedge clk_i);
        #1;
        sl_word = 8'h11;
        push(8'h12);
        n = 0;
        while (!m_axis_tvalid && n < 2000) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("t3_first_done", 32'(m_axis_tvalid), 32'd1);
        sl_word = 8'h22;
        s_axis_tdata = 8'h34; s_axis_tvalid = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        chk("t3_tready_held", 32'(s_axis_tready), 32'd0);
        chk("t3_tvalid_held", 32'(m_axis_tvalid), 32'd1);
        chk("t3_tdata_held",  32'(m_axis_tdata),  32'h11);
        chk("t3_cs_idle",     32'(spi_cs_n_o),    32'd1);
        m_axis_tready = 1'b1;
        @(posedge clk_i); #1;
        m_axis_tready = 1'b0;
        chk("t3_first_taken", 32'(m_axis_tvalid), 32'd0);
        push(8'h34);
        pull(rx, lat);
        chk("t3_second_rx", 32'(rx), 32'h22);
        chk("t3_slave_rx",  32'(sl_rx), 32'h34);

        // Divider 0 acts as 1; a mid-frame divider change is ignored
        clk_divider_i = 32'd0; sl_word = 8'h81;
        push(8'hFF);
        n = 0;
        while (busy_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
            if (n == 3) clk_divider_i = 32'd5;
        end
        chk("t4_busy_len", 32'(n), 32'd18);
        pull(rx, lat);
        chk("t4_rx",       32'(rx), 32'h81);
        chk("t4_lat",      32'(lat), 32'd19);
        chk("t4_slave_rx", 32'(sl_rx), 32'hFF);

        // Reset during SHIFT just before edge 7
        clk_divider_i = 32'd2; exp_gap = 4; sl_word = 8'h99;
        push(8'hF0);
        n = 0;
        while (sl_edges != 7 && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("t5_reach_edge7", 32'(sl_edges), 32'd7);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("t5_cs_n", 32'(spi_cs_n_o), 32'd1);
        chk("t5_sclk", 32'(spi_sclk_o), 32'd0);
        chk("t5_busy", 32'(busy_o), 32'd0);
        seen = 0;
        repeat (60) begin
            @(posedge clk_i); #1;
            if (m_axis_tvalid) seen = 1;
        end
        chk("t5_no_beat", 32'(seen), 32'd0);
        frame(8'h5A, 8'hC6, rx, lat);
        chk("t5_rx",       32'(rx), 32'hC6);
        chk("t5_slave_rx", 32'(sl_rx), 32'h5A);
        chk("t5_lat",      32'(lat), 32'd37);

        // All four modes at D=1 with random words
        clk_divider_i = 32'd1; exp_gap = 2;
        for (int m = 0; m < 4; m++) begin
            md = 2'(m);
            cpol_i = md[1]; cpha_i = md[0];
            repeat (2) @(posedge clk_i);
            #1;
            m0 = mosi_bad;
            for (int k = 0; k < 50; k++) begin
                tx = 8'($urandom_range(0, 255));
                sw = 8'($urandom_range(0, 255));
                frame(tx, sw, rx, lat);
                chk("t6_rx",       32'(rx), 32'(sw));
                chk("t6_slave_rx", 32'(sl_rx), 32'(tx));
            end
            chk("t6_mosi_edges", 32'(mosi_bad - m0), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
